// File: rtl/vending_machine_core.sv
// Single-product soda vend controller: sums nickel/dime/quarter credit, vends at PRICE, returns change in nickels.
// Latency: o_soda/o_change register one cycle after the completing coin edge. No backpressure; every coin is accepted.
// Optional VEND_COUNT_EN adds an 8-bit wrapping vend counter output o_vend_cnt.
module vending_machine_core #(
    parameter int PRICE = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_nickle,
    input  logic       i_dime,
    input  logic       i_quarter,
    output logic       o_soda,
    output logic [2:0] o_change
`ifdef VEND_COUNT_EN
    ,
    output logic [7:0] o_vend_cnt
`endif
);

    localparam logic [5:0] PRICE_C = 6'(PRICE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DISP  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [5:0] credit;
    logic [5:0] credit_next;
    logic [5:0] coin_value;
    logic [5:0] sum_next;
    logic [5:0] overpay;
    logic [2:0] change_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            credit   <= '0;
            o_change <= '0;
        end else begin
            state    <= state_next;
            credit   <= credit_next;
            o_change <= change_next;
        end
    end

    // Credit is below PRICE between vends, so the sum tops out at 55 and never overflows 6 bits.
    always_comb begin
        coin_value  = (i_nickle  ? 6'd5  : 6'd0)
                    + (i_dime    ? 6'd10 : 6'd0)
                    + (i_quarter ? 6'd25 : 6'd0);
        sum_next    = credit + coin_value;
        overpay     = sum_next - PRICE_C;
        state_next  = S_IDLE;
        credit_next = '0;
        change_next = '0;
        if (sum_next >= PRICE_C) begin
            state_next  = S_DISP;
            change_next = 3'(overpay / 6'd5);
        end else if (sum_next != 6'd0) begin
            state_next  = S_ACCUM;
            credit_next = sum_next;
        end
    end

    // The dispense strobe is the registered S_DISP state itself, so it lasts exactly one cycle per vend.
    assign o_soda = (state == S_DISP);

`ifdef VEND_COUNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vend_cnt <= '0;
        end else if (state_next == S_DISP) begin
            o_vend_cnt <= o_vend_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vending_machine_core.sv
module tb_vending_machine_core;

    localparam int PRICE = 20;

    logic       clk;
    logic       rst;
    logic       nickle;
    logic       dime;
    logic       quarter;
    logic       soda;
    logic [2:0] change;
`ifdef VEND_COUNT_EN
    logic [7:0] vend_cnt;
`endif

    vending_machine_core #(.PRICE(PRICE)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_nickle  (nickle),
        .i_dime    (dime),
        .i_quarter (quarter),
        .o_soda    (soda),
        .o_change  (change)
`ifdef VEND_COUNT_EN
        ,
        .o_vend_cnt(vend_cnt)
`endif
    );

    typedef struct {
        logic       soda;
        logic [2:0] change;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state: credit in cents and number of vends since reset.
    int   model_credit = 0;
    int   model_cnt    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic drive(input logic r, input logic n, input logic d, input logic q);
        int   total;
        exp_t e;
        @(negedge clk);
        rst     = r;
        nickle  = n;
        dime    = d;
        quarter = q;
        total   = model_credit + 5 * int'(n) + 10 * int'(d) + 25 * int'(q);
        e.soda   = 1'b0;
        e.change = 3'd0;
        if (r) begin
            model_credit = 0;
            model_cnt    = 0;
        end else if (total >= PRICE) begin
            model_credit = 0;
            model_cnt    = (model_cnt + 1) % 256;
            e.soda       = 1'b1;
            e.change     = 3'((total - PRICE) / 5);
        end else begin
            model_credit = total;
        end
        e.cnt = 8'(model_cnt);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected entry per driven cycle, checked just after the edge that consumed it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compared++;
                if (soda !== e.soda) begin
                    mismatched++;
                    $display("FAIL soda @%0t: got %b expected %b", $time, soda, e.soda);
                end
                compared++;
                if (change !== e.change) begin
                    mismatched++;
                    $display("FAIL change @%0t: got %0d expected %0d", $time, change, e.change);
                end
`ifdef VEND_COUNT_EN
                compared++;
                if (vend_cnt !== e.cnt) begin
                    mismatched++;
                    $display("FAIL vend_cnt @%0t: got %0d expected %0d", $time, vend_cnt, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        int waited;
        rst     = 1'b1;
        nickle  = 1'b0;
        dime    = 1'b0;
        quarter = 1'b0;

        // Reset for two cycles with no coins.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle();

        // Dime, gap, quarter: 35c -> change 3.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();

        // Nickel, dime, quarter back to back: 40c -> change 4.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();

        // Nickel, gap, quarter: 30c -> change 2.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();

        // Exact payment 5+10+5.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // Credit 15 then all three coins together: 55c -> change 7.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        idle();

        // Dime, reset, dime: no soda.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Quarter during the dispense cycle vends again with change 1.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();

        // Coins present during reset are discarded.
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        idle();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0));
        end
        idle();

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
